// File: rtl/rr_arbiter_16_if.sv
// Bundle of request/grant signals between the 16-way round-robin arbiter and its requesters.
// Request is level-held; a grant stays valid until done_in or a request drop is seen in GRANT.
interface rr_arbiter_16_if;
   logic [15:0] req_in;
   logic        done_in;
   logic [3:0]  gnt_idx_out;
   logic        gnt_en_out;
   logic [15:0] gnt_onehot_out;
   logic        timeout_out;

   modport master (
      input  req_in,
      input  done_in,
      output gnt_idx_out,
      output gnt_en_out,
      output gnt_onehot_out,
      output timeout_out
   );

   modport slave (
      output req_in,
      output done_in,
      input  gnt_idx_out,
      input  gnt_en_out,
      input  gnt_onehot_out,
      input  timeout_out
   );
endinterface

// File: rtl/rr_arbiter_16.sv
// 16-way round-robin arbiter with IDLE/GRANT FSM and registered index/one-hot grant.
// Optional grant hold timeout is compiled in with `define GRANT_TIMEOUT_EN.
module rr_arbiter_16 #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic              clk,
   input  logic              rst,
   rr_arbiter_16_if.master   bus,
   output logic              state_dbg
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state;
   logic [3:0] ptr;
   logic [3:0] pick;
   logic [3:0] cand;
   logic       found;
   logic       any_req;
   logic       release_req;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout_cycles
      $error("rr_arbiter_16: TIMEOUT_CYCLES must be in 1..255");
   end

   assign any_req     = |bus.req_in;
   assign release_req = bus.done_in || !bus.req_in[bus.gnt_idx_out];
   assign state_dbg   = state;

   // First requester at or after ptr, wrapping modulo 16.
   always_comb begin
      pick  = ptr;
      cand  = ptr;
      found = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cand = ptr + 4'(i);
         if (!found && bus.req_in[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

`ifdef GRANT_TIMEOUT_EN
   logic [7:0] hold_cnt;
   logic       hold_expired;

   // hold_cnt counts completed GRANT cycles, so this is the last allowed one.
   assign hold_expired = (hold_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
   assign bus.timeout_out = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         ptr                <= 4'd0;
         bus.gnt_idx_out    <= 4'd0;
         bus.gnt_en_out     <= 1'b0;
         bus.gnt_onehot_out <= 16'd0;
`ifdef GRANT_TIMEOUT_EN
         bus.timeout_out    <= 1'b0;
         hold_cnt           <= 8'd0;
`endif
      end else begin
`ifdef GRANT_TIMEOUT_EN
         bus.timeout_out <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (any_req) begin
                  state              <= GRANT;
                  bus.gnt_idx_out    <= pick;
                  bus.gnt_en_out     <= 1'b1;
                  bus.gnt_onehot_out <= 16'd1 << pick;
`ifdef GRANT_TIMEOUT_EN
                  hold_cnt           <= 8'd0;
`endif
               end
            end
            GRANT: begin
`ifdef GRANT_TIMEOUT_EN
               hold_cnt <= hold_cnt + 8'd1;
               if (release_req || hold_expired) begin
                  // A normal release wins over a simultaneous timeout.
                  bus.timeout_out <= !release_req;
`else
               if (release_req) begin
`endif
                  state              <= IDLE;
                  bus.gnt_en_out     <= 1'b0;
                  bus.gnt_onehot_out <= 16'd0;
                  ptr                <= bus.gnt_idx_out + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed self-checking bench for rr_arbiter_16; covers both builds of GRANT_TIMEOUT_EN.
module tb_rr_arbiter_16;

`ifdef GRANT_TIMEOUT_EN
   localparam int unsigned TO = 4;
`else
   localparam int unsigned TO = 15;
`endif

   logic clk;
   logic rst;
   logic state_dbg;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] exp_q[$];

   rr_arbiter_16_if bus ();

   rr_arbiter_16 #(.TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] req, input logic done);
      bus.req_in  = req;
      bus.done_in = done;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic expect_grant(input string tag, input int idx);
      logic [31:0] oh;
      oh = 32'd1 << idx;
      check_eq({tag, " en"}, 32'(bus.gnt_en_out), 32'd1);
      check_eq({tag, " idx"}, 32'(bus.gnt_idx_out), 32'(idx));
      check_eq({tag, " onehot"}, 32'(bus.gnt_onehot_out), oh);
      check_eq({tag, " state"}, 32'(state_dbg), 32'd1);
   endtask

   task automatic expect_idle(input string tag, input int idx);
      check_eq({tag, " en"}, 32'(bus.gnt_en_out), 32'd0);
      check_eq({tag, " idx"}, 32'(bus.gnt_idx_out), 32'(idx));
      check_eq({tag, " onehot"}, 32'(bus.gnt_onehot_out), 32'd0);
      check_eq({tag, " state"}, 32'(state_dbg), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      drive(16'h0201, 1'b1);
      tick();
      tick();
      expect_idle("reset", 0);
      check_eq("reset timeout", 32'(bus.timeout_out), 32'd0);

      // Idle with no requests
      rst = 1'b0;
      drive(16'h0000, 1'b0);
      tick();
      expect_idle("idle_noreq", 0);
      tick();
      expect_idle("idle_noreq2", 0);

      // Alternating 0/4 with one IDLE cycle between grants
      exp_q = '{32'd0, 32'd4, 32'd0, 32'd4};
      drive(16'h0011, 1'b0);
      while (exp_q.size() > 0) begin
         logic [31:0] e;
         e = exp_q.pop_front();
         tick();
         expect_grant("alt_grant", int'(e));
         drive(16'h0011, 1'b1);
         tick();
         expect_idle("alt_release", int'(e));
         drive(16'h0011, 1'b0);
      end
      drive(16'h0000, 1'b0);
      tick();
      expect_idle("alt_quiet", 4);

      // Wrap from 15 to 0; request present during release cycle
      drive(16'h8000, 1'b0);
      tick();
      expect_grant("grant15", 15);
      drive(16'h8001, 1'b1);
      tick();
      expect_idle("rel15", 15);
      drive(16'h8001, 1'b0);
      tick();
      expect_grant("wrap0", 0);
      drive(16'h0000, 1'b1);
      tick();
      expect_idle("rel0", 0);

      // Holder 3 ignores others, then drops while 2 is waiting
      drive(16'h0008, 1'b0);
      tick();
      expect_grant("grant3", 3);
      drive(16'h000F, 1'b0);
      tick();
      expect_grant("hold3_others", 3);
      drive(16'h0004, 1'b0);
      tick();
      expect_idle("drop3", 3);
      tick();
      expect_grant("grant2", 2);
      drive(16'h0000, 1'b1);
      tick();
      expect_idle("rel2", 2);

      // Simultaneous done and drop advance ptr only once
      drive(16'h0020, 1'b0);
      tick();
      expect_grant("grant5", 5);
      drive(16'h00C0, 1'b1);
      tick();
      expect_idle("rel5_both", 5);
      drive(16'h00C0, 1'b0);
      tick();
      expect_grant("single_adv6", 6);
      drive(16'h0000, 1'b1);
      tick();
      expect_idle("rel6", 6);

      // Long hold by requester 6
      drive(16'h0040, 1'b0);
      tick();
      expect_grant("hold6_start", 6);
`ifdef GRANT_TIMEOUT_EN
      for (int i = 1; i < 4; i++) begin
         tick();
         expect_grant("hold6", 6);
         check_eq("hold6 timeout", 32'(bus.timeout_out), 32'd0);
      end
      drive(16'h00C0, 1'b0);
      tick();
      expect_idle("timeout6", 6);
      check_eq("timeout pulse", 32'(bus.timeout_out), 32'd1);
      tick();
      expect_grant("after_timeout7", 7);
      check_eq("timeout single", 32'(bus.timeout_out), 32'd0);
      drive(16'h0000, 1'b1);
      tick();
      expect_idle("rel7", 7);
      check_eq("rel7 timeout", 32'(bus.timeout_out), 32'd0);

      // Release coinciding with timeout is a normal release
      drive(16'h0100, 1'b0);
      tick();
      expect_grant("grant8", 8);
      for (int i = 1; i < 4; i++) tick();
      drive(16'h0100, 1'b1);
      tick();
      expect_idle("rel8_at_limit", 8);
      check_eq("rel8 no timeout", 32'(bus.timeout_out), 32'd0);
      drive(16'h0000, 1'b0);
`else
      for (int i = 0; i < 100; i++) begin
         tick();
         check_eq("persist6 en", 32'(bus.gnt_en_out), 32'd1);
         check_eq("persist6 timeout", 32'(bus.timeout_out), 32'd0);
      end
      expect_grant("persist6_end", 6);
      drive(16'h0000, 1'b1);
      tick();
      expect_idle("rel6_long", 6);
      drive(16'h0000, 1'b0);
`endif
      tick();

      // Reset during a grant to 9
      drive(16'h0200, 1'b0);
      tick();
      expect_grant("grant9", 9);
      rst = 1'b1;
      tick();
      expect_idle("rst_mid_grant", 0);
      check_eq("rst_mid timeout", 32'(bus.timeout_out), 32'd0);
      rst = 1'b0;
      drive(16'h0201, 1'b0);
      tick();
      expect_grant("post_rst0", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_16.md
RR_ARBITER_16 -- requirements
Module: rr_arbiter_16

Interface
REQ-001: Parameter TIMEOUT_CYCLES, default 15, maximum grant hold in cycles; only used when GRANT_TIMEOUT_EN is defined; legal range 1..255.
REQ-002: clk  input  1  single clock; all logic on rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: req_in  input  16  per-requester request, level-sensitive; bit i = requester i.
REQ-005: done_in  input  1  current grant holder releases the resource; sampled only in GRANT.
REQ-006: gnt_idx_out  output  4  binary index of the granted requester; drives d_in of a 4x16 decoder.
REQ-007: gnt_en_out  output  1  grant valid; drives en of the decoder.
REQ-008: gnt_onehot_out  output  16  one-hot grant, bit gnt_idx_out set when gnt_en_out=1, all zero otherwise.
REQ-009: timeout_out  output  1  one-cycle pulse on a forced release.

Function
REQ-010: FSM states are IDLE and GRANT only.
REQ-011: Pointer ptr (4 bits) holds the highest-priority index; search order is ptr, ptr+1, ..., ptr+15, modulo 16.
REQ-012: IDLE with req_in==0: stay in IDLE, outputs unchanged at zero.
REQ-013: IDLE with req_in!=0: next cycle enter GRANT, gnt_idx_out = first set bit in search order, gnt_en_out=1; latency is one cycle from sampled request to grant.
REQ-014: GRANT: hold gnt_idx_out stable while req_in[gnt_idx_out]=1 and done_in=0.
REQ-015: GRANT with done_in=1 or req_in[gnt_idx_out]=0: next cycle enter IDLE, gnt_en_out=0, gnt_idx_out holds its last value, ptr = gnt_idx_out+1 modulo 16 (index 15 wraps to 0).
REQ-016: Exactly one IDLE cycle separates consecutive grants; a request present during a release cycle is arbitrated in that IDLE cycle.
REQ-017: Requests from non-granted requesters in GRANT do not affect the grant.
REQ-018: Simultaneous done_in=1 and drop of req_in[gnt_idx_out]: single release, ptr advances once.
REQ-019: gnt_onehot_out is registered with the other outputs, never combinationally derived from req_in.
REQ-020: gnt_en_out=1 never lasts more than one cycle with the corresponding req_in bit low.

Reset
REQ-021: rst=1 at a clock edge forces state IDLE, ptr=0, gnt_idx_out=0, gnt_en_out=0, gnt_onehot_out=0, timeout_out=0, hold counter=0.
REQ-022: Reset asserted mid-GRANT drops the grant on the next edge with no timeout pulse; ptr returns to 0 and does not advance.
REQ-023: While rst=1 all inputs are ignored; first arbitration is on the first edge with rst=0.

Configuration
REQ-024: Macro GRANT_TIMEOUT_EN compiles in an 8-bit hold counter, cleared on entry to GRANT and incremented each GRANT cycle.
REQ-025: With GRANT_TIMEOUT_EN defined, a holder reaching TIMEOUT_CYCLES GRANT cycles without release is forced to IDLE on the next edge, with timeout_out=1 for that one cycle and ptr advanced as in REQ-015.
REQ-026: If a normal release and the timeout occur in the same cycle, it is treated as a normal release and timeout_out stays 0.
REQ-027: Without GRANT_TIMEOUT_EN, the counter is absent, timeout_out is tied to 0 and a grant is held indefinitely.

Verification
REQ-028: rst=1 for 2 cycles, then req_in=16'h0000 -> all outputs 0, gnt_en_out stays 0.
REQ-029: From reset, req_in=16'h0011 held; done_in pulsed each GRANT -> grants alternate 0, 4, 0, 4, each followed by one IDLE cycle.
REQ-030: Grant to index 15 with done_in=1, then req_in=16'h8001 -> next grant index 0 (wrap), gnt_onehot_out=16'h0001.
REQ-031: Holder 3 drops req_in[3] while req_in[2] is high -> gnt_en_out=0 next cycle, then grant 2 after one IDLE cycle.
REQ-032: GRANT_TIMEOUT_EN with TIMEOUT_CYCLES=4, requester 6 held with done_in=0 -> forced release after 4 GRANT cycles, timeout_out pulses once, next search starts at 7; without the macro the grant persists for 100 cycles.
REQ-033: rst=1 during a grant to index 9 -> gnt_en_out=0 next edge, then req_in=16'h0201 -> grant index 0.
